// File: rtl/hart_slice_arbiter_pkg.sv
// Shared state encoding and width helper for the hart time-slice arbiter.
// Purely declarative: no logic, no timing.
package hart_arb_pkg;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] PEND   = 2'd1;
    localparam logic [1:0] SWITCH = 2'd2;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hart_slice_arbiter_if.sv
// Cluster-side bundle between the harts/MMU status and the slice arbiter.
// master = arbiter (drives grant/stall), slave = cluster muxes and hart status.
interface hart_slice_arbiter_if #(
    parameter int N_HARTS = 2,
    parameter int QW      = 16
);
    import hart_arb_pkg::*;

    localparam int SEL_W = sel_w(N_HARTS);

    logic [N_HARTS-1:0] i_ready;
    logic [N_HARTS-1:0] i_safe;
    logic [N_HARTS-1:0] i_irq;
    logic               i_mmu_idle;
    logic               i_hold;
    logic [QW-1:0]      i_quantum;
    logic [SEL_W-1:0]   o_sel;
    logic [N_HARTS-1:0] o_sel_oh;
    logic [N_HARTS-1:0] o_busy;
    logic               o_switch;
    logic [QW-1:0]      o_slice_cnt;

    modport master (
        input  i_ready, i_safe, i_irq, i_mmu_idle, i_hold, i_quantum,
        output o_sel, o_sel_oh, o_busy, o_switch, o_slice_cnt
    );

    modport slave (
        output i_ready, i_safe, i_irq, i_mmu_idle, i_hold, i_quantum,
        input  o_sel, o_sel_oh, o_busy, o_switch, o_slice_cnt
    );

endinterface

// File: rtl/hart_slice_arbiter_rr_pick.sv
// Round-robin find-first: first set bit of mask at or after start, wrapping mod N.
// Purely combinational; vld low when mask is empty.
module rr_pick #(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             vld
);

    // Scanning from the far end lets the closest hit overwrite later ones.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[(int'(start) + i) % N]) begin
                idx = SEL_W'((int'(start) + i) % N);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hart_slice_arbiter.sv
// Time-slice arbiter granting one hart the shared MMU port; grant moves 2 edges after a safe switch request.
// Optional HART_IRQ_PRIO_EN: interrupt-pending ready harts are preferred and force a switch request.
module hart_slice_arbiter
    import hart_arb_pkg::*;
#(
    parameter int N_HARTS = 2,
    parameter int QW      = 16
) (
    input logic                 CLK,
    input logic                 RST,
    hart_slice_arbiter_if.master bus
);

    localparam int               SEL_W = sel_w(N_HARTS);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_HARTS - 1);

    logic [1:0]         state, state_nxt;
    logic [SEL_W-1:0]   sel, target, start, rr_idx, pick_idx;
    logic [QW-1:0]      cnt, cnt_nxt;
    logic [N_HARTS-1:0] sel_oh, cand;
    logic               rr_vld, expired, want, safe, act, none;

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    assign start   = (sel == LAST) ? '0 : sel + 1'b1;
    assign cand    = bus.i_ready & ~sel_oh;
    assign expired = (bus.i_quantum != '0) && (cnt >= bus.i_quantum);
    // A single hart has nowhere to go, so it never waits for a safe point.
    assign safe    = (bus.i_safe[sel] && bus.i_mmu_idle) || (N_HARTS == 1);
    assign none    = !rr_vld;

    rr_pick #(.N(N_HARTS), .SEL_W(SEL_W)) u_rr (
        .mask  (cand),
        .start (start),
        .idx   (rr_idx),
        .vld   (rr_vld)
    );

`ifdef HART_IRQ_PRIO_EN
    logic [SEL_W-1:0] irq_idx;
    logic             irq_vld;

    rr_pick #(.N(N_HARTS), .SEL_W(SEL_W)) u_irq (
        .mask  (cand & bus.i_irq),
        .start (start),
        .idx   (irq_idx),
        .vld   (irq_vld)
    );

    assign pick_idx = irq_vld ? irq_idx : rr_idx;
    assign want     = expired || !bus.i_ready[sel] || irq_vld;
`else
    logic unused_irq;
    assign unused_irq = ^bus.i_irq;
    assign pick_idx   = rr_idx;
    assign want       = expired || !bus.i_ready[sel];
`endif

    always_ff @(posedge CLK) begin
        if (RST) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        act       = 1'b0;
        case (state)
            RUN: begin
                if (want && !bus.i_hold) begin
                    if (safe) act = 1'b1;
                    else      state_nxt = PEND;
                end
            end
            PEND: begin
                if (!want)                       state_nxt = RUN;
                else if (safe && !bus.i_hold)    act = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
        if (act) state_nxt = none ? RUN : SWITCH;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state == SWITCH || (act && none))
            cnt_nxt = '0;
        else if (!bus.i_hold && cnt < bus.i_quantum)
            cnt_nxt = cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel    <= '0;
            target <= '0;
            cnt    <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (act && !none)     target <= pick_idx;
            if (state == SWITCH)  sel    <= target;
        end
    end

    always_comb begin
        bus.o_sel       = sel;
        bus.o_sel_oh    = sel_oh;
        bus.o_slice_cnt = cnt;
        bus.o_switch    = (state == SWITCH);
        bus.o_busy      = (state == SWITCH) ? '1 : ~sel_oh;
        if (N_HARTS == 1) begin
            bus.o_busy   = '0;
            bus.o_switch = 1'b0;
        end
    end

endmodule

// File: tb/tb_hart_slice_arbiter.sv
// Self-checking bench for hart_slice_arbiter (4 harts) against a grant/counter reference model.
module tb_hart_slice_arbiter;

    localparam int NH = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [NH-1:0] ready = '1, safe = '1, irq = '0;
    logic          mmu_idle = 1'b1, hold = 1'b0;
    logic [15:0]   quantum = 16'd8;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: current grant, slice count, and an in-flight switch target.
    int m_sel = 0, m_cnt = 0, m_tgt = 0;
    bit m_sw  = 1'b0;

    always #5 CLK = ~CLK;

    hart_slice_arbiter_if #(.N_HARTS(NH), .QW(16)) bus ();

    assign bus.i_ready    = ready;
    assign bus.i_safe     = safe;
    assign bus.i_irq      = irq;
    assign bus.i_mmu_idle = mmu_idle;
    assign bus.i_hold     = hold;
    assign bus.i_quantum  = quantum;

    hart_slice_arbiter #(.N_HARTS(NH), .QW(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    function automatic int find_next(int from, logic [NH-1:0] m);
        for (int k = 1; k < NH; k++)
            if (m[(from + k) % NH]) return (from + k) % NH;
        return -1;
    endfunction

    task automatic model_step();
        int  t;
        bit  w;
        int  q;
        q = int'(quantum);
        if (RST) begin
            m_sel = 0; m_cnt = 0; m_sw = 1'b0; m_tgt = 0;
            return;
        end
        if (m_sw) begin
            m_sel = m_tgt; m_cnt = 0; m_sw = 1'b0;
            return;
        end
        w = (q != 0 && m_cnt >= q) || !ready[m_sel];
        t = find_next(m_sel, ready);
`ifdef HART_IRQ_PRIO_EN
        if (find_next(m_sel, ready & irq) >= 0) begin
            w = 1'b1;
            t = find_next(m_sel, ready & irq);
        end
`endif
        if (w && safe[m_sel] && mmu_idle && !hold) begin
            if (t < 0) begin
                m_cnt = 0;
                return;
            end
            m_tgt = t;
            m_sw  = 1'b1;
        end
        if (!hold && m_cnt < q) m_cnt++;
    endtask

    // Compare all outputs against the model, then advance one clock.
    task automatic tick();
        logic [NH-1:0] e_oh, e_busy;
        e_oh   = 4'b0001 << m_sel;
        e_busy = m_sw ? 4'hF : ~e_oh;
        checks++;
        if (bus.o_sel !== 2'(m_sel)) begin
            errors++; $display("FAIL o_sel cyc=%0d got %0d want %0d", cyc, bus.o_sel, m_sel);
        end
        checks++;
        if (bus.o_sel_oh !== e_oh) begin
            errors++; $display("FAIL o_sel_oh cyc=%0d got %b want %b", cyc, bus.o_sel_oh, e_oh);
        end
        checks++;
        if (bus.o_busy !== e_busy) begin
            errors++; $display("FAIL o_busy cyc=%0d got %b want %b", cyc, bus.o_busy, e_busy);
        end
        checks++;
        if (bus.o_switch !== m_sw) begin
            errors++; $display("FAIL o_switch cyc=%0d got %b want %b", cyc, bus.o_switch, m_sw);
        end
        checks++;
        if (bus.o_slice_cnt !== 16'(m_cnt)) begin
            errors++; $display("FAIL o_slice_cnt cyc=%0d got %0d want %0d", cyc, bus.o_slice_cnt, m_cnt);
        end
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        m_sel = 0; m_cnt = 0; m_sw = 1'b0; m_tgt = 0;
        RST = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        ready = '1; safe = '1; irq = '0; mmu_idle = 1'b1; hold = 1'b0; quantum = 16'd8;
        do_reset();
        checks++;
        if (bus.o_sel !== 2'd0 || bus.o_sel_oh !== 4'b0001 || bus.o_busy !== 4'hE ||
            bus.o_switch !== 1'b0 || bus.o_slice_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset got sel=%0d oh=%b busy=%b sw=%b cnt=%0d want 0/0001/1110/0/0",
                     bus.o_sel, bus.o_sel_oh, bus.o_busy, bus.o_switch, bus.o_slice_cnt);
        end
    endtask

    task automatic test_rotation();
        ready = '1; safe = '1; quantum = 16'd8;
        do_reset();
        while (cyc < 45) begin
            if (cyc == 9) begin
                checks++;
                if (bus.o_switch !== 1'b1) begin
                    errors++; $display("FAIL rot_switch9 got %b want 1", bus.o_switch);
                end
            end
            if (cyc == 10 || cyc == 20 || cyc == 30 || cyc == 40) begin
                checks++;
                if (bus.o_sel !== 2'((cyc / 10) % NH)) begin
                    errors++; $display("FAIL rot_sel cyc=%0d got %0d want %0d", cyc, bus.o_sel, (cyc / 10) % NH);
                end
            end
            tick();
        end
    endtask

    task automatic test_pend();
        ready = '1; safe = 4'b1110; quantum = 16'd8;
        do_reset();
        while (cyc < 25) begin
            if (cyc == 19) safe = '1;
            if (cyc == 20) begin
                checks++;
                if (bus.o_switch !== 1'b1 || bus.o_busy !== 4'hF) begin
                    errors++; $display("FAIL pend_switch20 got sw=%b busy=%b want 1/1111", bus.o_switch, bus.o_busy);
                end
            end
            if (cyc == 21) begin
                checks++;
                if (bus.o_sel !== 2'd1) begin
                    errors++; $display("FAIL pend_sel21 got %0d want 1", bus.o_sel);
                end
            end
            tick();
        end
    endtask

    task automatic test_skip_idle();
        ready = 4'b0101; safe = '1; quantum = 16'd0;
        do_reset();
        while (cyc < 12) begin
            if (cyc == 5) ready = 4'b0100;
            if (cyc == 7) begin
                checks++;
                if (bus.o_sel !== 2'd2) begin
                    errors++; $display("FAIL skip_sel7 got %0d want 2", bus.o_sel);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_ready();
        bit saw_sw;
        saw_sw = 1'b0;
        ready = 4'b0001; safe = '1; quantum = 16'd4;
        do_reset();
        while (cyc < 22) begin
            if (bus.o_switch === 1'b1) saw_sw = 1'b1;
            if (cyc == 5 || cyc == 10 || cyc == 15) begin
                checks++;
                if (bus.o_slice_cnt !== 16'd0) begin
                    errors++; $display("FAIL single_cnt cyc=%0d got %0d want 0", cyc, bus.o_slice_cnt);
                end
            end
            tick();
        end
        checks++;
        if (saw_sw !== 1'b0) begin
            errors++; $display("FAIL single_no_switch got 1 want 0");
        end
    endtask

    task automatic test_hold_reset();
        int budget;
        ready = '1; safe = '1; quantum = 16'd8;
        do_reset();
        while (cyc < 31) begin
            hold = (cyc >= 3);
            if (cyc == 20) begin
                checks++;
                if (bus.o_slice_cnt !== 16'd3 || bus.o_switch !== 1'b0) begin
                    errors++; $display("FAIL hold_frozen got cnt=%0d sw=%b want 3/0", bus.o_slice_cnt, bus.o_switch);
                end
            end
            tick();
        end
        hold   = 1'b0;
        budget = 40;
        while (bus.o_switch !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++; $display("FAIL hold_release_switch got none within 40 cycles want a switch");
        end else begin
            RST = 1'b1;
            tick();
            RST = 1'b0;
            checks++;
            if (bus.o_sel !== 2'd0 || bus.o_busy !== 4'hE || bus.o_switch !== 1'b0) begin
                errors++; $display("FAIL reset_mid_switch got sel=%0d busy=%b sw=%b want 0/1110/0",
                                   bus.o_sel, bus.o_busy, bus.o_switch);
            end
            repeat (12) tick();
        end
    endtask

`ifdef HART_IRQ_PRIO_EN
    task automatic test_irq_prio();
        ready = '1; safe = '1; irq = 4'b1000; quantum = 16'd100;
        do_reset();
        while (cyc < 8) begin
            if (cyc == 1) begin
                checks++;
                if (bus.o_switch !== 1'b1) begin
                    errors++; $display("FAIL irq_switch1 got %b want 1", bus.o_switch);
                end
            end
            if (cyc == 2) begin
                checks++;
                if (bus.o_sel !== 2'd3) begin
                    errors++; $display("FAIL irq_sel2 got %0d want 3", bus.o_sel);
                end
            end
            tick();
        end
        irq = '0;
    endtask
`endif

    task automatic test_random();
        logic [15:0] qtab [6];
        qtab[0] = 16'd0; qtab[1] = 16'd1; qtab[2] = 16'd2;
        qtab[3] = 16'd3; qtab[4] = 16'd5; qtab[5] = 16'd8;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) quantum = qtab[$urandom_range(0, 5)];
            for (int b = 0; b < NH; b++) begin
                ready[b] = ($urandom_range(0, 3) != 0);
                safe[b]  = ($urandom_range(0, 2) != 0);
                irq[b]   = ($urandom_range(0, 7) == 0);
            end
            mmu_idle = ($urandom_range(0, 7) != 0);
            hold     = ($urandom_range(0, 7) == 0);
            RST      = ($urandom_range(0, 199) == 0);
            tick();
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_pend();
        test_skip_idle();
        test_single_ready();
        test_hold_reset();
`ifdef HART_IRQ_PRIO_EN
        test_irq_prio();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
